// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812/SK6812 strip driver.
// Pixel width depends on WS2812_RGBW_EN (defined: 32-bit {G,R,B,W}; undefined: 24-bit {G,R,B}).
package ws2812_pkg;

`ifdef WS2812_RGBW_EN
  localparam int unsigned PIX_W = 32;
`else
  localparam int unsigned PIX_W = 24;
`endif

  // Default timing for a 12 MHz clock.
  localparam int unsigned DEF_T_PERIOD = 15;
  localparam int unsigned DEF_T1H      = 10;
  localparam int unsigned DEF_T0H      = 5;
  localparam int unsigned DEF_T_RESET  = 600;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StBits,
    StGap
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Emits one T_PERIOD-long WS2812 bit waveform per strobe; bit_done_o marks the final cycle so
// a strobe in that cycle chains the next bit without a gap.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned T_PERIOD = DEF_T_PERIOD,
  parameter int unsigned T1H      = DEF_T1H,
  parameter int unsigned T0H      = DEF_T0H
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  input  logic bit_i,
  output logic wave_o,
  output logic bit_done_o
);

  localparam int unsigned CW = clog2_min1(T_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_q, bit_d;
  logic          active_q, active_d;
  logic          wave_q, wave_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
      wave_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      wave_q   <= wave_d;
    end
  end

  always_comb begin
    bit_done_o = active_q && (cnt_q == CW'(T_PERIOD - 1));
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    active_d   = active_q;
    if (strobe_i) begin
      cnt_d    = '0;
      bit_d    = bit_i;
      active_d = 1'b1;
    end else if (bit_done_o) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Level for the coming cycle, so the pin itself is a flop.
    wave_d = active_d && (cnt_d < (bit_d ? CW'(T1H) : CW'(T0H)));
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/ws2812_strip.sv
// WS2812/SK6812 strip driver: LEDS-deep framebuffer, frame serialiser and latch gap.
// Build option WS2812_RGBW_EN selects 32-bit RGBW pixels (see ws2812_pkg).
module ws2812_strip
  import ws2812_pkg::*;
#(
  parameter int unsigned LEDS     = 8,
  parameter int unsigned T_PERIOD = DEF_T_PERIOD,
  parameter int unsigned T1H      = DEF_T1H,
  parameter int unsigned T0H      = DEF_T0H,
  parameter int unsigned T_RESET  = DEF_T_RESET,
  parameter int unsigned AUTO     = 0,
  localparam int unsigned AW      = clog2_min1(LEDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_pix,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             data
);

  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned BW  = clog2_min1(PIX_W);
  localparam int unsigned GW  = clog2_min1(T_RESET + 1);

  localparam logic [AW:0]   LedsCnt = AW1'(LEDS);
  localparam logic [AW-1:0] LastPix = AW'(LEDS - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    pix_idx_q, pix_idx_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic             pend_q, pend_d;

  logic [PIX_W-1:0] mem_q [LEDS];
  logic [PIX_W-1:0] rd_data_q;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      nxt_pix;

  logic enc_strobe, enc_bit, bit_done;
  logic last_bit, last_pix, gap_last;

  // Simple dual-port RAM; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < LedsCnt)) begin
      mem_q[wr_addr] <= wr_pix;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  // Pixel 0 is read while idle/gapping; during a frame the next pixel is read every cycle, so the
  // word captured at the pixel boundary reflects writes up to the previous cycle.
  always_comb begin
    nxt_pix = {1'b0, pix_idx_q} + AW1'(1);
    rd_addr = '0;
    if ((state_q == StLoad || state_q == StBits) && (nxt_pix < LedsCnt)) begin
      rd_addr = nxt_pix[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pix_idx_q <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
      shift_q   <= shift_d;
      pend_q    <= pend_d;
    end
  end

  assign last_bit = (bit_idx_q == BW'(PIX_W - 1));
  assign last_pix = (pix_idx_q == LastPix);
  assign gap_last = (gap_q == GW'(T_RESET - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = StBits;
      StBits: if (bit_done && last_bit && last_pix) state_d = StGap;
      StGap: begin
        if (gap_last) state_d = (AUTO != 0 || pend_q || start) ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_idx_d  = pix_idx_q;
    bit_idx_d  = bit_idx_q;
    gap_d      = '0;
    shift_d    = shift_q;
    pend_d     = 1'b0;
    enc_strobe = 1'b0;
    enc_bit    = shift_q[PIX_W-1];
    unique case (state_q)
      StIdle: begin
        pix_idx_d = '0;
        bit_idx_d = '0;
      end
      StLoad: begin
        shift_d    = rd_data_q;
        enc_strobe = 1'b1;
        enc_bit    = rd_data_q[PIX_W-1];
        pix_idx_d  = '0;
        bit_idx_d  = '0;
      end
      StBits: begin
        if (bit_done && !last_bit) begin
          shift_d    = shift_q << 1;
          bit_idx_d  = bit_idx_q + BW'(1);
          enc_strobe = 1'b1;
          enc_bit    = shift_q[PIX_W-2];
        end else if (bit_done && !last_pix) begin
          shift_d    = rd_data_q;
          bit_idx_d  = '0;
          pix_idx_d  = pix_idx_q + AW'(1);
          enc_strobe = 1'b1;
          enc_bit    = rd_data_q[PIX_W-1];
        end
      end
      StGap: begin
        gap_d  = gap_last ? '0 : gap_q + GW'(1);
        pend_d = (pend_q || start) && !gap_last;
      end
      default: ;
    endcase
    busy = (state_q != StIdle);
    done = (state_q == StGap) && gap_last;
  end

  ws2812_bit_encoder #(
    .T_PERIOD(T_PERIOD),
    .T1H     (T1H),
    .T0H     (T0H)
  ) u_enc (
    .clk       (clk),
    .reset     (reset),
    .strobe_i  (enc_strobe),
    .bit_i     (enc_bit),
    .wave_o    (data),
    .bit_done_o(bit_done)
  );

endmodule

// File: tb/tb_ws2812_strip.sv
// Self-checking bench for ws2812_strip: frame waveforms compared against a bit-timing model,
// plus mid-frame writes, start-in-gap, mid-frame reset and auto-refresh period.
module tb_ws2812_strip;
  import ws2812_pkg::*;

  localparam int unsigned LEDS = 2;
  localparam int unsigned TP   = 15;
  localparam int unsigned T1H  = 10;
  localparam int unsigned T0H  = 5;
  localparam int unsigned TR   = 600;
  localparam int unsigned AW   = 1;
  localparam int N   = LEDS * PIX_W * TP;
  localparam int CAP = N + TR + 2;

  typedef logic [PIX_W-1:0] pix_t;
  typedef struct {
    pix_t p0;
    pix_t p1;
    int   ones;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0, start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  pix_t          wr_pix = '0;
  logic          busy, done, data;

  logic          a_wr_en = 1'b0, a_start = 1'b0;
  logic [AW-1:0] a_wr_addr = '0;
  pix_t          a_wr_pix = '0;
  logic          a_busy, a_done, a_data;

  ws2812_strip #(
    .LEDS(LEDS), .T_PERIOD(TP), .T1H(T1H), .T0H(T0H), .T_RESET(TR), .AUTO(0)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pix(wr_pix),
    .start(start), .busy(busy), .done(done), .data(data)
  );

  ws2812_strip #(
    .LEDS(LEDS), .T_PERIOD(TP), .T1H(T1H), .T0H(T0H), .T_RESET(TR), .AUTO(1)
  ) u_auto (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_pix(a_wr_pix),
    .start(a_start), .busy(a_busy), .done(a_done), .data(a_data)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  pix_t model_mem [LEDS];
  pix_t snap [LEDS];
  logic cap_data [CAP];
  logic cap_busy [CAP];
  logic cap_done [CAP];
  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected pin level at cycle i of the bit stream, from the WS2812 timing rules.
  function automatic logic ref_level(input int i, input pix_t px [LEDS]);
    int   pix, bitn, ph;
    logic b;
    if (i < 0 || i >= N) return 1'b0;
    pix  = i / (PIX_W * TP);
    bitn = (i / TP) % PIX_W;
    ph   = i % TP;
    b    = px[pix][PIX_W-1-bitn];
    return (ph < (b ? T1H : T0H));
  endfunction

  task automatic write_pix(input int a, input pix_t p);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_pix  = p;
    tick();
    wr_en = 1'b0;
    model_mem[a] = p;
  endtask

  task automatic start_frame(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_load"}, {busy, data, done}, 3'b100);
  endtask

  // Records CAP cycles starting with the first bit cycle; optional write / start at one index.
  task automatic capture(input int wr_at, input int wa, input pix_t wp, input int st_at);
    for (int i = 0; i < CAP; i++) begin
      wr_en   = (i == wr_at);
      wr_addr = AW'(wa);
      wr_pix  = wp;
      start   = (i == st_at);
      tick();
      cap_data[i] = data;
      cap_busy[i] = busy;
      cap_done[i] = done;
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic compare_frame(input string name, input pix_t px [LEDS], input bit rerun);
    int   md = 0, mb = 0, mdn = 0;
    logic ed, eb, edn;
    for (int i = 0; i < CAP; i++) begin
      ed  = ref_level(i, px);
      eb  = (i < N + int'(TR)) || rerun;
      edn = (i == N + int'(TR) - 1);
      if (rerun && i == N + int'(TR) + 1) ed = 1'b1;
      if (cap_data[i] !== ed) md++;
      if (cap_busy[i] !== eb) mb++;
      if (cap_done[i] !== edn) mdn++;
    end
    check({name, "_data_mismatch_cycles"}, md, 0);
    check({name, "_busy_mismatch_cycles"}, mb, 0);
    check({name, "_done_mismatch_cycles"}, mdn, 0);
  endtask

  function automatic int measured_ones();
    int h = 0;
    for (int i = 0; i < N; i++) h += int'(cap_data[i]);
    return (h - N / int'(TP) * int'(T0H)) / int'(T1H - T0H);
  endfunction

  initial begin
    int   t, iv, held, d1, d2;
    pix_t p0, p1;

    vecs[0] = '{pix_t'(32'hFF0000), pix_t'(32'h000001), 9};
    vecs[1] = '{pix_t'(32'h000000), pix_t'(32'h000000), 0};
    vecs[2] = '{pix_t'(32'h0000FF), pix_t'(32'hAA5500), 16};
    vecs[3] = '{pix_t'(32'h123456), pix_t'(32'h800000), 10};

    repeat (3) tick();
    check("reset_outputs", {busy, done, data}, 3'b000);
    check("reset_outputs_auto", {a_busy, a_done, a_data}, 3'b000);
    reset = 1'b0;
    tick();

    // Directed table: full frame waveform plus independent ones count.
    for (int v = 0; v < 4; v++) begin
      write_pix(0, vecs[v].p0);
      write_pix(1, vecs[v].p1);
      start_frame($sformatf("vec%0d", v));
      capture(-1, 0, '0, -1);
      snap = model_mem;
      compare_frame($sformatf("vec%0d", v), snap, 1'b0);
      check($sformatf("vec%0d_ones", v), measured_ones(), vecs[v].ones);
    end

    // Write to pixel 1 while pixel 0 shifts: visible in this frame.
    write_pix(0, pix_t'(32'hF0F0F0));
    write_pix(1, pix_t'(32'h0F0F0F));
    start_frame("wr_later");
    capture(100, 1, pix_t'(32'hC3C3C3), -1);
    model_mem[1] = pix_t'(32'hC3C3C3);
    snap = model_mem;
    compare_frame("wr_later", snap, 1'b0);

    // Write to pixel 0 while it shifts: old value now, new value next frame.
    snap = model_mem;
    start_frame("wr_cur");
    capture(100, 0, pix_t'(32'h00FF00), -1);
    compare_frame("wr_cur", snap, 1'b0);
    model_mem[0] = pix_t'(32'h00FF00);
    start_frame("wr_cur_next");
    capture(-1, 0, '0, -1);
    snap = model_mem;
    compare_frame("wr_cur_next", snap, 1'b0);

    // Start during the gap: frame reruns with no idle cycle.
    start_frame("gap_start");
    capture(-1, 0, '0, N + 100);
    snap = model_mem;
    compare_frame("gap_start", snap, 1'b1);
    t = 0;
    while (busy && t < 5000) begin
      tick();
      t++;
    end
    check("gap_start_rerun_ends", busy, 0);

    // Reset in the middle of bit 5 of pixel 0.
    write_pix(0, pix_t'(32'hA5A5A5));
    write_pix(1, pix_t'(32'h5A5A5A));
    start_frame("mid_reset");
    repeat (5 * TP + 7) tick();
    reset = 1'b1;
    tick();
    check("mid_reset_outputs", {busy, done, data}, 3'b000);
    reset = 1'b0;
    held = 0;
    for (int i = 0; i < N + int'(TR) + 10; i++) begin
      tick();
      held += int'(done) + int'(busy) + int'(data);
    end
    check("mid_reset_quiet", held, 0);
    start_frame("after_reset");
    capture(-1, 0, '0, -1);
    snap = model_mem;
    compare_frame("after_reset", snap, 1'b0);

    // Randomised pixels against the model.
    for (int r = 0; r < 4; r++) begin
      p0 = pix_t'($urandom);
      p1 = pix_t'($urandom);
      write_pix(0, p0);
      write_pix(1, p1);
      repeat ($urandom_range(0, 3)) tick();
      start_frame($sformatf("rand%0d", r));
      capture(-1, 0, '0, -1);
      snap = model_mem;
      compare_frame($sformatf("rand%0d", r), snap, 1'b0);
    end

    // Auto-refresh: done-to-done period equals one start-to-start interval.
    a_wr_en = 1'b1;
    a_wr_addr = 1'b0;
    a_wr_pix = pix_t'(32'h818181);
    tick();
    a_wr_addr = 1'b1;
    a_wr_pix = pix_t'(32'h7E7E7E);
    tick();
    a_wr_en = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    t = 0;
    while (!a_done && t < 3000) begin
      tick();
      t++;
    end
    check("auto_first_done", a_done, 1);
    iv = 0;
    held = 1;
    d1 = 0;
    d2 = 0;
    do begin
      tick();
      iv++;
      held = held & int'(a_busy);
      if (iv == 1) d1 = int'(a_data);
      if (iv == 2) d2 = int'(a_data);
    end while (!a_done && iv < 3000);
    check("auto_period", iv, 1 + N + int'(TR));
    check("auto_busy_held", held, 1);
    check("auto_load_low_then_high", {d1[0], d2[0]}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
